parking_display_ctrl: RTL and testbench

Parametrised parking-lot front end: debounces N_SLOTS occupancy sensors, registers the lowest-numbered vacant slot, the free-slot count and a full flag. It drives a 4-digit time-multiplexed, active-low seven-segment display with both numbers in decimal. It sits directly behind the sensor pins at the top level.

---
 rtl/parking_pkg.sv | 41 ++++
 rtl/parking_display_ctrl_debouncer.sv | 38 +++
 rtl/parking_display_ctrl.sv | 102 ++++++++++
 tb/tb_parking_display_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - seven-segment patterns and sizing helpers for the parking display
package parking_pkg;

   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   function automatic logic [6:0] digit_to_seg(input logic [6:0] d);
      case (d)
         7'd0:    digit_to_seg = SEG_0;
         7'd1:    digit_to_seg = SEG_1;
         7'd2:    digit_to_seg = SEG_2;
         7'd3:    digit_to_seg = SEG_3;
         7'd4:    digit_to_seg = SEG_4;
         7'd5:    digit_to_seg = SEG_5;
         7'd6:    digit_to_seg = SEG_6;
         7'd7:    digit_to_seg = SEG_7;
         7'd8:    digit_to_seg = SEG_8;
         7'd9:    digit_to_seg = SEG_9;
         default: digit_to_seg = SEG_BLANK;
      endcase
   endfunction

   function automatic int refresh_width(input int div);
      return (div > 2) ? $clog2(div) : 1;
   endfunction

   localparam int REFRESH_DIV_DEFAULT = 100000;
   localparam int REFRESH_W_DEFAULT   = refresh_width(REFRESH_DIV_DEFAULT);

endpackage

// File: rtl/parking_display_ctrl_debouncer.sv
// rtl/parking_display_ctrl_debouncer.sv - per-slot 2-flop synchroniser and debounce filter
module slot_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic filtered
);
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          meta;
   logic          sync;
   logic [CW-1:0] cnt;

   // The counter tracks consecutive samples disagreeing with the filtered bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta     <= 1'b0;
         sync     <= 1'b0;
         cnt      <= '0;
         filtered <= 1'b0;
      end else begin
         meta <= raw;
         sync <= meta;
         if (sync == filtered) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            filtered <= sync;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/parking_display_ctrl.sv
// rtl/parking_display_ctrl.sv - parking occupancy status and 4-digit multiplexed display driver
module parking_display_ctrl
   import parking_pkg::*;
#(
   parameter int N_SLOTS         = 15,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REFRESH_DIV     = 100000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_SLOTS-1:0] cars,
   output logic [6:0]         vacant_slot,
   output logic [6:0]         free_count,
   output logic               full,
   output logic [6:0]         seg,
   output logic [3:0]         an
);
   localparam int RW = refresh_width(REFRESH_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);

   logic [N_SLOTS-1:0] filtered;

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      slot_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk      (clk),
         .rst      (rst),
         .raw      (cars[i]),
         .filtered (filtered[i])
      );
   end

   logic [6:0] lowest_free;
   logic [6:0] n_free;
   logic       found;

   always_comb begin
      lowest_free = '0;
      n_free      = '0;
      found       = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!filtered[i]) begin
            n_free = n_free + 7'd1;
            if (!found) begin
               lowest_free = 7'(i + 1);
               found       = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vacant_slot <= 7'd1;
         free_count  <= 7'(N_SLOTS);
         full        <= 1'b0;
      end else begin
         vacant_slot <= lowest_free;
         free_count  <= n_free;
         full        <= (n_free == 7'd0);
      end
   end

   logic [RW-1:0] refresh_cnt;
   logic [1:0]    digit_idx;
   logic [1:0]    digit_next;
   logic          wrap;
   logic [6:0]    vs_tens, vs_ones, fc_tens, fc_ones;
   logic [6:0]    seg_next;

   // seg is built for the digit that will be lit after this edge, so an and seg switch together
   always_comb begin
      wrap       = (refresh_cnt == REFRESH_LAST);
      digit_next = wrap ? digit_idx + 2'd1 : digit_idx;
      vs_tens    = vacant_slot / 7'd10;
      vs_ones    = vacant_slot % 7'd10;
      fc_tens    = free_count / 7'd10;
      fc_ones    = free_count % 7'd10;
      seg_next   = SEG_BLANK;
      case (digit_next)
         2'd0:    seg_next = full ? SEG_DASH : digit_to_seg(vs_ones);
         2'd1:    seg_next = full ? SEG_DASH :
                             (vs_tens == 7'd0) ? SEG_BLANK : digit_to_seg(vs_tens);
         2'd2:    seg_next = digit_to_seg(fc_ones);
         default: seg_next = (fc_tens == 7'd0) ? SEG_BLANK : digit_to_seg(fc_tens);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_cnt <= '0;
         digit_idx   <= 2'd0;
         an          <= 4'b1110;
         seg         <= SEG_1;
      end else begin
         refresh_cnt <= wrap ? '0 : refresh_cnt + RW'(1);
         digit_idx   <= digit_next;
         an          <= ~(4'b0001 << digit_next);
         seg         <= seg_next;
      end
   end

endmodule

// File: tb/tb_parking_display_ctrl.sv
// tb/tb_parking_display_ctrl.sv - scoreboard bench for parking_display_ctrl
module tb_parking_display_ctrl;
   localparam int N = 15;
   localparam int D = 4;
   localparam int R = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] cars;
   logic [6:0]   vacant_slot, free_count, seg;
   logic         full;
   logic [3:0]   an;

   parking_display_ctrl #(.N_SLOTS(N), .DEBOUNCE_CYCLES(D), .REFRESH_DIV(R)) dut (
      .clk         (clk),
      .rst         (rst),
      .cars        (cars),
      .vacant_slot (vacant_slot),
      .free_count  (free_count),
      .full        (full),
      .seg         (seg),
      .an          (an)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [6:0] vac;
      logic [6:0] free;
      logic       fl;
      logic [3:0] an;
      logic [6:0] seg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   // Reference state: accepted occupancy, status after the last edge, edge count since reset
   logic [N-1:0] filt_m;
   logic [N-1:0] samples[$];
   int           st_vac, st_free;
   bit           st_full;
   int           k;

   function automatic logic [6:0] digit_pat(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] disp(input int dig, input int vac, input int free, input bit fl);
      case (dig)
         0: return fl ? 7'b0111111 : digit_pat(vac % 10);
         1: return fl ? 7'b0111111 : ((vac / 10 == 0) ? 7'b1111111 : digit_pat(vac / 10));
         2: return digit_pat(free % 10);
         default: return (free / 10 == 0) ? 7'b1111111 : digit_pat(free / 10);
      endcase
   endfunction

   function automatic exp_t reset_exp();
      exp_t e;
      e.vac  = 7'd1;
      e.free = 7'(N);
      e.fl   = 1'b0;
      e.an   = 4'b1110;
      e.seg  = 7'b1111001;
      return e;
   endfunction

   task automatic model_reset();
      filt_m  = '0;
      st_vac  = 1;
      st_free = N;
      st_full = 1'b0;
      k       = 0;
      samples.delete();
      repeat (D + 2) samples.push_back('0);
   endtask

   // A slot flips once the last D synchronised samples all disagree with its accepted value
   task automatic model_step(input logic [N-1:0] c, output exp_t e);
      int           dig, nv, nf;
      logic [N-1:0] nfilt;
      bit           all_diff;
      k++;
      dig   = (k / R) % 4;
      e.an  = 4'b1111 ^ (4'b0001 << dig);
      e.seg = disp(dig, st_vac, st_free, st_full);
      nv = 0;
      nf = 0;
      for (int i = 0; i < N; i++) begin
         if (!filt_m[i]) begin
            nf++;
            if (nv == 0) nv = i + 1;
         end
      end
      st_vac  = nv;
      st_free = nf;
      st_full = (nf == 0);
      e.vac   = 7'(nv);
      e.free  = 7'(nf);
      e.fl    = st_full;
      nfilt   = filt_m;
      for (int i = 0; i < N; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < D; j++)
            if (samples[samples.size() - 2 - j][i] == filt_m[i]) all_diff = 1'b0;
         if (all_diff) nfilt[i] = ~filt_m[i];
      end
      filt_m = nfilt;
      samples.push_back(c);
      if (samples.size() > D + 2) void'(samples.pop_front());
   endtask

   task automatic cycle(input logic [N-1:0] c, input logic r);
      exp_t e;
      @(posedge clk);
      #1;
      cars = c;
      if (r) begin
         if (!rst && sb.size() > 0) begin
            sb.delete(sb.size() - 1);
            sb.push_back(reset_exp());
         end
         rst = 1'b1;
         model_reset();
         sb.push_back(reset_exp());
      end else begin
         rst = 1'b0;
         model_step(c, e);
         sb.push_back(e);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if ({vacant_slot, free_count, full, an, seg} !== e) begin
            errors++;
            $display("FAIL status_display t=%0t: got vac=%0d free=%0d full=%b an=%b seg=%b, expected vac=%0d free=%0d full=%b an=%b seg=%b",
                     $time, vacant_slot, free_count, full, an, seg, e.vac, e.free, e.fl, e.an, e.seg);
         end
      end
   end

   initial begin
      #1000000;
      if (!done) begin
         errors++;
         $display("FAIL timeout t=%0t: stimulus did not complete, %0d checks done", $time, checks);
         $finish;
      end
   end

   initial begin
      logic [N-1:0] cur;
      int           hold;
      exp_t         r_exp;
      rst  = 1'b1;
      cars = '0;
      model_reset();
      sb.push_back(reset_exp());
      repeat (3) cycle('0, 1'b1);
      #1;
      r_exp = reset_exp();
      checks++;
      if ({vacant_slot, free_count, full, an, seg} !== r_exp) begin
         errors++;
         $display("FAIL reset_state t=%0t: got vac=%0d free=%0d full=%b an=%b seg=%b",
                  $time, vacant_slot, free_count, full, an, seg);
      end
      repeat (20) cycle('0, 1'b0);
      repeat (12) cycle(15'h0001, 1'b0);
      repeat (3) cycle(15'h0009, 1'b0);
      repeat (12) cycle(15'h0001, 1'b0);
      repeat (24) cycle(15'h7FFF, 1'b0);
      repeat (12) cycle('0, 1'b0);
      repeat (4) cycle(15'h0020, 1'b0);
      repeat (2) cycle(15'h0020, 1'b1);
      repeat (14) cycle(15'h0020, 1'b0);
      cur = '0;
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 9))
            0, 1: cur = 15'($urandom());
            2:    cur = ($urandom_range(0, 1) == 1) ? 15'h7FFF : 15'h0000;
            3:    cycle(cur ^ (15'd1 << $urandom_range(0, N - 1)), 1'b0);
            4:    if ($urandom_range(0, 19) == 0) cycle(cur, 1'b1);
            default: cur = cur ^ (15'd1 << $urandom_range(0, N - 1));
         endcase
         hold = $urandom_range(1, 8);
         repeat (hold) cycle(cur, 1'b0);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      done = 1'b1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
